// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state encoding and default width for the multiply/divide unit.
package mdu_pkg;

  localparam int MDU_W = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring divider datapath: unsigned magnitudes in, one quotient bit per step.
module mdu_div_iter
  import mdu_pkg::*;
#(
  parameter int W     = MDU_W,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         last,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem
);

  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W:0]       rem_sh;
  logic [W-1:0]     rem_sub;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    // Shift the next dividend bit into the partial remainder; quo doubles as the shift source.
    rem_sh  = {rem_q, quo_q[W-1]};
    rem_sub = rem_sh[W-1:0] - dvs_q;
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = '0;
    end else if (step) begin
      if (rem_sh >= {1'b0, dvs_q}) begin
        rem_d = rem_sub;
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_W'(W - 1));
  assign quo  = quo_q;
  assign rem  = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO; 1-cycle multiply, W-step restoring divide.
// Optional MDU_MADD_EN adds the MADD/MSUB accumulate path; without it ops 6/7 complete with no HI/LO write.
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int W     = MDU_W,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  // Handshake: an op is taken on a rising edge where req_valid && req_ready;
  // req_op/req_src* are sampled only on that edge and never read again.
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_src1,
  input  logic [W-1:0] req_src2,
  input  logic         cancel,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output mdu_state_e   dbg_state
);

  mdu_state_e   state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic [W-1:0] src1_q, src1_d;
  logic [W-1:0] src2_q, src2_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;
  logic         done_q, done_d;
  logic         q_neg_q, q_neg_d;
  logic         r_neg_q, r_neg_d;

  logic         accept;
  logic         is_sdiv, a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;
  logic         div_start, div_step, div_last;
  logic [W-1:0] div_quo, div_rem;
  logic         mul_sgn;
  logic [W:0]   mul_a, mul_b;
  logic [2*W-1:0] prod;

  assign accept = req_valid && req_ready;

  // Unsigned W-bit negate gives the true magnitude even for the most negative value.
  assign is_sdiv = (req_op == OP_DIV);
  assign a_neg   = is_sdiv && req_src1[W-1];
  assign b_neg   = is_sdiv && req_src2[W-1];
  assign a_mag   = a_neg ? (-req_src1) : req_src1;
  assign b_mag   = b_neg ? (-req_src2) : req_src2;

  assign mul_sgn = (op_q != OP_MULTU);
  assign mul_a   = {mul_sgn & src1_q[W-1], src1_q};
  assign mul_b   = {mul_sgn & src2_q[W-1], src2_q};
  assign prod    = $signed({{(W-1){mul_a[W]}}, mul_a}) * $signed({{(W-1){mul_b[W]}}, mul_b});

  mdu_div_iter #(.W(W), .CNT_W(CNT_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .last     (div_last),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    div_start = 1'b0;
    div_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = req_op;
          src1_d = req_src1;
          src2_d = req_src2;
          if (is_mul_op(req_op)) begin
            state_d = ST_MUL;
          end else if ((req_op == OP_DIV) || (req_op == OP_DIVU)) begin
            state_d   = ST_DIV;
            div_start = 1'b1;
            q_neg_d   = a_neg ^ b_neg;
            r_neg_d   = a_neg;
          end else if (req_op == OP_MTHI) begin
            hi_d   = req_src1;
            done_d = 1'b1;
          end else begin
            lo_d   = req_src1;
            done_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        case (op_q)
          OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
`ifdef MDU_MADD_EN
          OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod;
          OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod;
`endif
          default: ;
        endcase
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (div_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        lo_d    = q_neg_q ? (-div_quo) : div_quo;
        hi_d    = r_neg_q ? (-div_rem) : div_rem;
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Cancel wins over everything, including the commit edge of MUL/FIX.
    if (cancel) begin
      state_d  = ST_IDLE;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      div_step = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE) && !cancel;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector table plus hand-written cancel/back-to-back sequences for muldiv_unit (W=32).
module tb_muldiv_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_src1;
  logic [W-1:0] req_src2;
  logic         cancel;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  mdu_state_e   dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit #(.W(W), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---- scoreboard ----
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---- driver tasks (entered and left #1 after a rising edge) ----
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until done is seen; flags ready/busy misbehaviour while waiting.
  task automatic wait_done(input int max_edges, output int lat, output bit rdy_bad);
    lat     = -1;
    rdy_bad = 1'b0;
    for (int i = 0; i <= max_edges; i++) begin
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      if (!(busy === 1'b1 && req_ready === 1'b0)) rdy_bad = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int         exp_lat;
  } vec_t;

  vec_t vecs[19];

  initial begin
    int lat;
    bit rdy_bad;
    bit seen;
    int steps;

    vecs[0]  = '{"mult_m1x2",    OP_MULT,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1};
    vecs[1]  = '{"multu_m1x2",   OP_MULTU, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 1};
    vecs[2]  = '{"multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1};
    vecs[3]  = '{"mult_m1xm1",   OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1};
    vecs[4]  = '{"mult_min2",    OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1};
    vecs[5]  = '{"mult_7xm3",    OP_MULT,  32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1};
    vecs[6]  = '{"div_m7_2",     OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[7]  = '{"divu_5_0",     OP_DIVU,  32'h5,        32'h0,        32'h00000005, 32'hFFFFFFFF, 33};
    vecs[8]  = '{"div_min_m1",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[9]  = '{"div_7_0",      OP_DIV,   32'h7,        32'h0,        32'h00000007, 32'hFFFFFFFF, 33};
    vecs[10] = '{"div_m7_0",     OP_DIV,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'h00000001, 33};
    vecs[11] = '{"divu_100_3",   OP_DIVU,  32'd100,      32'd3,        32'h00000001, 32'h00000021, 33};
    vecs[12] = '{"div_100_m7",   OP_DIV,   32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 33};
    vecs[13] = '{"div_m100_7",   OP_DIV,   32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 33};
    vecs[14] = '{"divu_max_10",  OP_DIVU,  32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, 33};
    vecs[15] = '{"mthi_0",       OP_MTHI,  32'h0,        32'h0,        32'h00000000, 32'h19999999, 0};
    vecs[16] = '{"mtlo_5",       OP_MTLO,  32'h5,        32'h0,        32'h00000000, 32'h00000005, 0};
`ifdef MDU_MADD_EN
    vecs[17] = '{"madd_3_4",     OP_MADD,  32'd3,        32'd4,        32'h00000000, 32'h00000011, 1};
    vecs[18] = '{"msub_6_3",     OP_MSUB,  32'd6,        32'd3,        32'hFFFFFFFF, 32'hFFFFFFFF, 1};
`else
    vecs[17] = '{"madd_3_4",     OP_MADD,  32'd3,        32'd4,        32'h00000000, 32'h00000005, 1};
    vecs[18] = '{"msub_6_3",     OP_MSUB,  32'd6,        32'd3,        32'h00000000, 32'h00000005, 1};
`endif

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_src1  = '0;
    req_src2  = '0;
    cancel    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi",    64'(hi),        64'h0);
    check("rst_lo",    64'(lo),        64'h0);
    check("rst_done",  64'(done),      64'h0);
    check("rst_busy",  64'(busy),      64'h0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'h1);

    // ---- vector table ----
    foreach (vecs[k]) begin
      issue(vecs[k].op, vecs[k].a, vecs[k].b);
      wait_done(60, lat, rdy_bad);
      check({vecs[k].name, "_lat"}, 64'(lat), 64'(vecs[k].exp_lat));
      check({vecs[k].name, "_hi"},  64'(hi),  64'(vecs[k].exp_hi));
      check({vecs[k].name, "_lo"},  64'(lo),  64'(vecs[k].exp_lo));
      if (vecs[k].exp_lat > 0) check({vecs[k].name, "_rdy_busy"}, 64'(rdy_bad), 64'h0);
      @(posedge clk);
      #1;
      check({vecs[k].name, "_done_1cyc"}, 64'(done), 64'h0);
    end

    // ---- cancel 10 cycles into a divide ----
    issue(OP_MTHI, 32'hA, 32'h0);
    issue(OP_MTLO, 32'hB, 32'h0);
    check("pre_hi", 64'(hi), 64'hA);
    check("pre_lo", 64'(lo), 64'hB);
    issue(OP_DIVU, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    check("c10_busy_before", 64'(busy), 64'h1);
    cancel = 1'b1;
    #1;
    check("c10_ready_under_cancel", 64'(req_ready), 64'h0);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    #1;
    check("c10_done",  64'(done),      64'h0);
    check("c10_busy",  64'(busy),      64'h0);
    check("c10_ready", 64'(req_ready), 64'h1);
    check("c10_hi",    64'(hi),        64'hA);
    check("c10_lo",    64'(lo),        64'hB);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    check("c10_no_late_done", 64'(seen), 64'h0);
    check("c10_hi_late", 64'(hi), 64'hA);
    check("c10_lo_late", 64'(lo), 64'hB);

    // ---- cancel on the FIX (commit) edge ----
    issue(OP_DIVU, 32'd100, 32'd3);
    steps = -1;
    for (int i = 0; i <= 40; i++) begin
      if (dbg_state === ST_FIX) begin
        steps = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("cfix_edges_to_fix", 64'(steps), 64'd32);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    #1;
    check("cfix_done",  64'(done),      64'h0);
    check("cfix_busy",  64'(busy),      64'h0);
    check("cfix_ready", 64'(req_ready), 64'h1);
    check("cfix_hi",    64'(hi),        64'hA);
    check("cfix_lo",    64'(lo),        64'hB);

    // ---- valid together with cancel in IDLE is ignored ----
    req_valid = 1'b1;
    req_op    = OP_MTLO;
    req_src1  = 32'h77;
    cancel    = 1'b1;
    #1;
    check("vc_ready", 64'(req_ready), 64'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cancel    = 1'b0;
    check("vc_done", 64'(done), 64'h0);
    check("vc_lo",   64'(lo),   64'hB);

    // ---- cancel on the MUL commit edge ----
    issue(OP_MULT, 32'd3, 32'd5);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cmul_done", 64'(done), 64'h0);
    check("cmul_busy", 64'(busy), 64'h0);
    check("cmul_hilo", {hi, lo}, {32'hA, 32'hB});

    // ---- back-to-back: MULT accepted in the done cycle of a divide ----
    issue(OP_DIVU, 32'd100, 32'd3);
    wait_done(60, lat, rdy_bad);
    check("b2b_div_lat", 64'(lat), 64'd33);
    check("b2b_div_hilo", {hi, lo}, {32'h1, 32'h21});
    check("b2b_ready_in_done", 64'(req_ready), 64'h1);
    issue(OP_MULT, 32'd3, 32'd5);
    check("b2b_accepted_busy", 64'(busy), 64'h1);
    check("b2b_done_low", 64'(done), 64'h0);
    @(posedge clk);
    #1;
    check("b2b_mul_done", 64'(done), 64'h1);
    check("b2b_mul_hilo", {hi, lo}, {32'h0, 32'hF});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
